// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the byte-serialising memory controller.
// Length codes, FSM states and byte lane helpers.
package mem_ctrl_pkg;

  typedef logic [7:0] byte_t;

  localparam logic [1:0] LEN_BYTE = 2'd0;
  localparam logic [1:0] LEN_HALF = 2'd1;
  localparam logic [1:0] LEN_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    IF_RD,
    MEM_RD,
    MEM_WR
  } state_t;

  function automatic logic [2:0] nbytes(input logic [1:0] len);
    case (len)
      LEN_BYTE: return 3'd1;
      LEN_HALF: return 3'd2;
      default:  return 3'd4;
    endcase
  endfunction

  function automatic byte_t get_byte(
    input logic [31:0] w,
    input logic [1:0]  i
  );
    return w[{i, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] put_byte(
    input logic [31:0] w,
    input logic [1:0]  i,
    input byte_t       b
  );
    logic [31:0] r;
    r = w;
    r[{i, 3'b000} +: 8] = b;
    return r;
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Request/response and RAM signals of the memory controller.
// master = requesters plus RAM, slave = mem_ctrl.
interface mem_ctrl_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  if_read;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_ready;
  logic [31:0]           if_data;
  logic                  mem_read;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [1:0]            mem_len;
  logic [31:0]           mem_wdata;
  logic                  mem_ready;
  logic [31:0]           mem_rdata;
  logic [ADDR_WIDTH-1:0] ram_a;
  logic                  ram_wr;
  logic [7:0]            ram_dout;
  logic [7:0]            ram_din;

  modport master (
    output if_read, if_addr,
    output mem_read, mem_write,
    output mem_addr, mem_len, mem_wdata,
    output ram_din,
    input  if_ready, if_data,
    input  mem_ready, mem_rdata,
    input  ram_a, ram_wr, ram_dout
  );

  modport slave (
    input  if_read, if_addr,
    input  mem_read, mem_write,
    input  mem_addr, mem_len, mem_wdata,
    input  ram_din,
    output if_ready, if_data,
    output mem_ready, mem_rdata,
    output ram_a, ram_wr, ram_dout
  );
endinterface

// File: rtl/mem_ctrl.sv
// Serialises IF/MEM 1/2/4-byte transfers onto a byte-wide RAM
// with one-cycle read latency; all outputs are registered.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter bit MEM_FIRST  = 1'b1
) (
  input  logic clk,
  input  logic reset,
  mem_ctrl_if.slave bus
);

  typedef logic [ADDR_WIDTH-1:0] addr_t;

  state_t      state, state_n;
  addr_t       addr_q, addr_n;
  logic [1:0]  len_q, len_n;
  logic [31:0] wdata_q, wdata_n;
  logic [2:0]  cnt, cnt_n;
  logic [31:0] asm_q, asm_n;
  addr_t       ram_a_q, ram_a_n;
  logic        ram_wr_q, ram_wr_n;
  byte_t       ram_dout_q, ram_dout_n;
  logic        if_ready_q, if_ready_n;
  logic [31:0] if_data_q, if_data_n;
  logic        mem_ready_q, mem_ready_n;
  logic [31:0] mem_rdata_q, mem_rdata_n;

  logic [2:0]  n;
  logic [2:0]  cnt_inc;
  logic [1:0]  cap_idx;
  addr_t       nxt_a;
  logic [31:0] merged;
  logic        take_mem;

  assign n        = nbytes(len_q);
  assign cnt_inc  = cnt + 3'd1;
  assign cap_idx  = 2'(cnt - 3'd1);
  assign nxt_a    = addr_q + ADDR_WIDTH'(cnt_inc);
  assign merged   = put_byte(asm_q, cap_idx, bus.ram_din);
  assign take_mem = (bus.mem_read | bus.mem_write)
                  & (MEM_FIRST | ~bus.if_read);

  always_comb begin
    state_n     = state;
    addr_n      = addr_q;
    len_n       = len_q;
    wdata_n     = wdata_q;
    cnt_n       = cnt;
    asm_n       = asm_q;
    ram_a_n     = ram_a_q;
    ram_wr_n    = 1'b0;
    ram_dout_n  = ram_dout_q;
    if_ready_n  = 1'b0;
    if_data_n   = if_data_q;
    mem_ready_n = 1'b0;
    mem_rdata_n = mem_rdata_q;
    unique case (state)
      IDLE: begin
        if (take_mem) begin
          addr_n  = bus.mem_addr;
          len_n   = bus.mem_len;
          wdata_n = bus.mem_wdata;
          cnt_n   = 3'd0;
          asm_n   = 32'd0;
          ram_a_n = bus.mem_addr;
          if (bus.mem_write) begin
            state_n    = MEM_WR;
            ram_wr_n   = 1'b1;
            ram_dout_n = bus.mem_wdata[7:0];
          end else begin
            state_n = MEM_RD;
          end
        end else if (bus.if_read) begin
          state_n = IF_RD;
          addr_n  = bus.if_addr;
          len_n   = LEN_WORD;
          cnt_n   = 3'd0;
          asm_n   = 32'd0;
          ram_a_n = bus.if_addr;
        end
      end
      IF_RD: begin
        if (!bus.if_read) begin
          state_n = IDLE;
        end else if (bus.if_addr != addr_q) begin
          // branch redirect: restart as a fresh accept
          addr_n  = bus.if_addr;
          cnt_n   = 3'd0;
          asm_n   = 32'd0;
          ram_a_n = bus.if_addr;
        end else begin
          if (cnt != 3'd0) asm_n = merged;
          if (cnt == n) begin
            state_n    = IDLE;
            if_ready_n = 1'b1;
            if_data_n  = merged;
          end else begin
            cnt_n = cnt_inc;
            if (cnt_inc < n) ram_a_n = nxt_a;
          end
        end
      end
      MEM_RD: begin
        if (cnt != 3'd0) asm_n = merged;
        if (cnt == n) begin
          state_n     = IDLE;
          mem_ready_n = 1'b1;
          mem_rdata_n = merged;
        end else begin
          cnt_n = cnt_inc;
          if (cnt_inc < n) ram_a_n = nxt_a;
        end
      end
      MEM_WR: begin
        if (cnt_inc < n) begin
          cnt_n      = cnt_inc;
          ram_wr_n   = 1'b1;
          ram_a_n    = nxt_a;
          ram_dout_n = get_byte(wdata_q, cnt_inc[1:0]);
        end else begin
          state_n     = IDLE;
          mem_ready_n = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      addr_q      <= '0;
      len_q       <= 2'd0;
      wdata_q     <= 32'd0;
      cnt         <= 3'd0;
      asm_q       <= 32'd0;
      ram_a_q     <= '0;
      ram_wr_q    <= 1'b0;
      ram_dout_q  <= 8'd0;
      if_ready_q  <= 1'b0;
      if_data_q   <= 32'd0;
      mem_ready_q <= 1'b0;
      mem_rdata_q <= 32'd0;
    end else begin
      state       <= state_n;
      addr_q      <= addr_n;
      len_q       <= len_n;
      wdata_q     <= wdata_n;
      cnt         <= cnt_n;
      asm_q       <= asm_n;
      ram_a_q     <= ram_a_n;
      ram_wr_q    <= ram_wr_n;
      ram_dout_q  <= ram_dout_n;
      if_ready_q  <= if_ready_n;
      if_data_q   <= if_data_n;
      mem_ready_q <= mem_ready_n;
      mem_rdata_q <= mem_rdata_n;
    end
  end

  assign bus.ram_a     = ram_a_q;
  assign bus.ram_wr    = ram_wr_q;
  assign bus.ram_dout  = ram_dout_q;
  assign bus.if_ready  = if_ready_q;
  assign bus.if_data   = if_data_q;
  assign bus.mem_ready = mem_ready_q;
  assign bus.mem_rdata = mem_rdata_q;

endmodule
